// File: rtl/sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// sram_ctrl_pkg : shared types and constants for the SRAM access controller.
// Revision      : 1.0
// ============================================================================
package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        ACCESS  = 3'd2,
        DTACK   = 3'd3,
        RECOVER = 3'd4
    } state_t;

    localparam int NUM_BLOCKS    = 4;
    localparam int BLOCK_SEL_MSB = 16;
    localparam int BLOCK_SEL_W   = $clog2(NUM_BLOCKS);
    localparam int WAIT_CNT_W    = 4;
    localparam int REC_CNT_W     = 3;

    localparam logic [NUM_BLOCKS-1:0] CE_ALL_OFF = '1;
    localparam logic                  CTRL_OFF   = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sram_block_select.sv
`default_nettype none
// ============================================================================
// sram_block_select : registered 2-to-4 active-low one-hot chip-enable decode.
// Revision          : 1.0
// ============================================================================
module sram_block_select
    import sram_ctrl_pkg::*;
(
    input  logic                   Clk,
    input  logic                   Reset_L,
    input  logic                   i_en,
    input  logic [BLOCK_SEL_W-1:0] i_sel,
    output logic [NUM_BLOCKS-1:0]  o_ce_l
);

    always_ff @(posedge Clk or negedge Reset_L) begin
        if (!Reset_L) begin
            o_ce_l <= CE_ALL_OFF;
        end else if (i_en) begin
            o_ce_l <= ~(NUM_BLOCKS'(1) << i_sel);
        end else begin
            o_ce_l <= CE_ALL_OFF;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_access_controller.sv
`default_nettype none
// ============================================================================
// sram_access_controller : 68k bus-cycle sequencer for 4 x 64 KB SRAM blocks.
// Optional block-0 write protection with bus error: SRAM_WRITE_PROTECT_EN.
// Revision               : 1.0
// ============================================================================
module sram_access_controller
    import sram_ctrl_pkg::*;
#(
    parameter int WAIT_STATES     = 2,
    parameter int RECOVERY_CYCLES = 1
) (
    input  logic                  Clk,
    input  logic                  Reset_L,
    input  logic [16:0]           Address,
    input  logic                  AS_L,
    input  logic                  UDS_L,
    input  logic                  LDS_L,
    input  logic                  RW,
    input  logic                  SRamSelect_H,
`ifdef SRAM_WRITE_PROTECT_EN
    input  logic                  WriteProtect_H,
    output logic                  Berr_L,
`endif
    output logic [NUM_BLOCKS-1:0] Block_CE_L,
    output logic                  SRam_OE_L,
    output logic                  SRam_WE_L,
    output logic                  SRam_UB_L,
    output logic                  SRam_LB_L,
    output logic                  Dtack_L,
    output logic                  Busy_H
);

    state_t                 r_state, w_state_nxt;
    logic [WAIT_CNT_W-1:0]  r_wait_cnt;
    logic [REC_CNT_W-1:0]   r_rec_cnt;
    logic [BLOCK_SEL_W-1:0] r_blk, w_blk_nxt;
    logic                   r_rd, r_uds_l, r_lds_l, r_berr;
    logic                   w_rd_nxt, w_uds_nxt, w_lds_nxt, w_berr_nxt;
    logic                   w_start, w_latch, w_wp_hit, w_active;
    logic                   w_unused_addr;

    assign w_start       = !AS_L && SRamSelect_H && (!UDS_L || !LDS_L);
    assign w_latch       = (r_state == IDLE) && w_start;
    assign w_unused_addr = ^Address[BLOCK_SEL_MSB-BLOCK_SEL_W:0];

`ifdef SRAM_WRITE_PROTECT_EN
    assign w_wp_hit = WriteProtect_H && !RW &&
                      (Address[BLOCK_SEL_MSB -: BLOCK_SEL_W] == '0);
`else
    assign w_wp_hit = 1'b0;
`endif

    // Outputs are registered from the next state, so the request attributes
    // must be visible on the same edge that latches them.
    assign w_blk_nxt  = w_latch ? Address[BLOCK_SEL_MSB -: BLOCK_SEL_W] : r_blk;
    assign w_rd_nxt   = w_latch ? RW       : r_rd;
    assign w_uds_nxt  = w_latch ? UDS_L    : r_uds_l;
    assign w_lds_nxt  = w_latch ? LDS_L    : r_lds_l;
    assign w_berr_nxt = w_latch ? w_wp_hit : r_berr;

    always_ff @(posedge Clk or negedge Reset_L) begin
        if (!Reset_L) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_nxt = w_wp_hit ? DTACK : SETUP;
                end
            end
            SETUP: begin
                w_state_nxt = AS_L ? RECOVER : ACCESS;
            end
            ACCESS: begin
                if (AS_L) begin
                    w_state_nxt = RECOVER;
                end else if (r_wait_cnt == '0) begin
                    w_state_nxt = DTACK;
                end
            end
            DTACK: begin
                if (AS_L) begin
                    w_state_nxt = RECOVER;
                end
            end
            RECOVER: begin
                if (r_rec_cnt <= REC_CNT_W'(1)) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_L) begin
        if (!Reset_L) begin
            r_wait_cnt <= '0;
            r_rec_cnt  <= '0;
            r_blk      <= '0;
            r_rd       <= 1'b1;
            r_uds_l    <= CTRL_OFF;
            r_lds_l    <= CTRL_OFF;
            r_berr     <= 1'b0;
        end else begin
            if (w_latch) begin
                r_blk   <= Address[BLOCK_SEL_MSB -: BLOCK_SEL_W];
                r_rd    <= RW;
                r_uds_l <= UDS_L;
                r_lds_l <= LDS_L;
                r_berr  <= w_wp_hit;
            end
            if (r_state == SETUP) begin
                r_wait_cnt <= WAIT_CNT_W'(WAIT_STATES);
            end else if ((r_state == ACCESS) && (r_wait_cnt != '0)) begin
                r_wait_cnt <= r_wait_cnt - WAIT_CNT_W'(1);
            end
            if ((w_state_nxt == RECOVER) && (r_state != RECOVER)) begin
                r_rec_cnt <= REC_CNT_W'(RECOVERY_CYCLES);
            end else if ((r_state == RECOVER) && (r_rec_cnt != '0)) begin
                r_rec_cnt <= r_rec_cnt - REC_CNT_W'(1);
            end
        end
    end

    // A protected write reaches DTACK without ever touching the devices.
    assign w_active = ((w_state_nxt == SETUP) || (w_state_nxt == ACCESS) ||
                       (w_state_nxt == DTACK)) && !w_berr_nxt;

    always_ff @(posedge Clk or negedge Reset_L) begin
        if (!Reset_L) begin
            SRam_OE_L <= CTRL_OFF;
            SRam_WE_L <= CTRL_OFF;
            SRam_UB_L <= CTRL_OFF;
            SRam_LB_L <= CTRL_OFF;
            Dtack_L   <= CTRL_OFF;
            Busy_H    <= 1'b0;
        end else begin
            SRam_OE_L <= !(w_active && w_rd_nxt);
            SRam_WE_L <= !(w_active && !w_rd_nxt && (w_state_nxt == ACCESS));
            SRam_UB_L <= w_active ? w_uds_nxt : CTRL_OFF;
            SRam_LB_L <= w_active ? w_lds_nxt : CTRL_OFF;
            Dtack_L   <= !(w_active && (w_state_nxt == DTACK));
            Busy_H    <= (w_state_nxt != IDLE);
        end
    end

`ifdef SRAM_WRITE_PROTECT_EN
    always_ff @(posedge Clk or negedge Reset_L) begin
        if (!Reset_L) begin
            Berr_L <= CTRL_OFF;
        end else begin
            Berr_L <= !(w_berr_nxt && (w_state_nxt == DTACK));
        end
    end
`endif

    sram_block_select u_block_select (
        .Clk     (Clk),
        .Reset_L (Reset_L),
        .i_en    (w_active),
        .i_sel   (w_blk_nxt),
        .o_ce_l  (Block_CE_L)
    );

endmodule
`default_nettype wire

// File: tb/tb_sram_access_controller.sv
`default_nettype none
// ============================================================================
// tb_sram_access_controller : two configurations (WS2/RC1 and WS0/RC3) driven
// by directed and random bus cycles, checked against an edge-count model.
// ============================================================================
module tb_sram_access_controller;

    localparam int N   = 2;
    localparam int WS0 = 2;
    localparam int RC0 = 1;
    localparam int WS1 = 0;
    localparam int RC1 = 3;
    // {CE[3:0], OE, WE, UB, LB, DTACK, BUSY, BERR}
    localparam logic [10:0] IDLE_V = 11'b1111_1111_101;

    logic        Clk = 1'b0;
    logic        Reset_L, AS_L, UDS_L, LDS_L, RW, SRamSelect_H;
    logic [16:0] Address;
`ifdef SRAM_WRITE_PROTECT_EN
    logic        WriteProtect_H;
`endif

    logic [3:0]  ce   [N];
    logic        oe   [N];
    logic        we   [N];
    logic        ub   [N];
    logic        lb   [N];
    logic        dt   [N];
    logic        busy [N];
    logic        berr [N];
    logic [10:0] obs  [N];

    int n_cmp = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    sram_access_controller #(.WAIT_STATES(WS0), .RECOVERY_CYCLES(RC0)) u_dut0 (
        .Clk(Clk), .Reset_L(Reset_L), .Address(Address), .AS_L(AS_L),
        .UDS_L(UDS_L), .LDS_L(LDS_L), .RW(RW), .SRamSelect_H(SRamSelect_H),
`ifdef SRAM_WRITE_PROTECT_EN
        .WriteProtect_H(WriteProtect_H), .Berr_L(berr[0]),
`endif
        .Block_CE_L(ce[0]), .SRam_OE_L(oe[0]), .SRam_WE_L(we[0]),
        .SRam_UB_L(ub[0]), .SRam_LB_L(lb[0]), .Dtack_L(dt[0]), .Busy_H(busy[0])
    );

    sram_access_controller #(.WAIT_STATES(WS1), .RECOVERY_CYCLES(RC1)) u_dut1 (
        .Clk(Clk), .Reset_L(Reset_L), .Address(Address), .AS_L(AS_L),
        .UDS_L(UDS_L), .LDS_L(LDS_L), .RW(RW), .SRamSelect_H(SRamSelect_H),
`ifdef SRAM_WRITE_PROTECT_EN
        .WriteProtect_H(WriteProtect_H), .Berr_L(berr[1]),
`endif
        .Block_CE_L(ce[1]), .SRam_OE_L(oe[1]), .SRam_WE_L(we[1]),
        .SRam_UB_L(ub[1]), .SRam_LB_L(lb[1]), .Dtack_L(dt[1]), .Busy_H(busy[1])
    );

`ifndef SRAM_WRITE_PROTECT_EN
    assign berr[0] = 1'b1;
    assign berr[1] = 1'b1;
`endif

    always_comb begin
        for (int i = 0; i < N; i++) begin
            obs[i] = {ce[i], oe[i], we[i], ub[i], lb[i], dt[i], busy[i], berr[i]};
        end
    end

    function automatic int ws_of(input int i);
        return (i == 0) ? WS0 : WS1;
    endfunction

    function automatic int rc_of(input int i);
        return (i == 0) ? RC0 : RC1;
    endfunction

    // Model: a bus cycle is accepted at edge s and ends at edge a (first edge
    // after s seeing AS_L high). Outputs follow from the distances to s and a.
    int          k = 0;
    bit          m_act  [N];
    int          m_s    [N];
    int          m_a    [N];
    int          m_free [N];
    logic        m_rd   [N];
    logic        m_ub   [N];
    logic        m_lb   [N];
    logic        m_berr [N];
    logic [1:0]  m_blk  [N];
    logic [10:0] exp_v  [N];

    function automatic logic [10:0] model_out(input int i);
        logic [3:0] c;
        logic       o, w, u, l, d, b, e;
        int         dedge;
        c = 4'hF; o = 1'b1; w = 1'b1; u = 1'b1; l = 1'b1; d = 1'b1; e = 1'b1;
        dedge = m_s[i] + ws_of(i) + 2;
        b = m_act[i] || (k < m_a[i] + rc_of(i));
        if (m_act[i]) begin
            if (m_berr[i]) begin
                e = 1'b0;
            end else begin
                c[m_blk[i]] = 1'b0;
                u = m_ub[i];
                l = m_lb[i];
                o = !m_rd[i];
                w = !(!m_rd[i] && (k >= m_s[i] + 1) && (k < dedge));
                d = !(k >= dedge);
            end
        end
        return {c, o, w, u, l, d, b, e};
    endfunction

    always @(posedge Clk) begin : p_model
        bit st;
        k  = k + 1;
        st = !AS_L && SRamSelect_H && (!UDS_L || !LDS_L);
        for (int i = 0; i < N; i++) begin
            if (!Reset_L) begin
                m_act[i]  = 1'b0;
                m_a[i]    = -100;
                m_free[i] = 0;
            end else if (m_act[i]) begin
                if ((k > m_s[i]) && AS_L) begin
                    m_act[i]  = 1'b0;
                    m_a[i]    = k;
                    m_free[i] = k + rc_of(i) + 1;
                end
            end else if ((k >= m_free[i]) && st) begin
                m_act[i]  = 1'b1;
                m_s[i]    = k;
                m_rd[i]   = RW;
                m_ub[i]   = UDS_L;
                m_lb[i]   = LDS_L;
                m_blk[i]  = Address[16:15];
                m_berr[i] = 1'b0;
`ifdef SRAM_WRITE_PROTECT_EN
                m_berr[i] = WriteProtect_H && !RW && (Address[16:15] == 2'd0);
`endif
            end
            exp_v[i] = model_out(i);
        end
        #1;
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (obs[i] !== exp_v[i]) begin
                n_err++;
                $display("FAIL model_dut%0d edge %0d: got %b expected %b", i, k, obs[i], exp_v[i]);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #2;
        end
    endtask

    task automatic edge3;
        @(posedge Clk);
        #3;
    endtask

    task automatic idle_bus(input int n);
        AS_L  = 1'b1;
        UDS_L = 1'b1;
        LDS_L = 1'b1;
        tick(n);
    endtask

    task automatic req(input logic [16:0] a, input logic rw, input logic u, input logic l);
        Address      = a;
        RW           = rw;
        UDS_L        = u;
        LDS_L        = l;
        SRamSelect_H = 1'b1;
        AS_L         = 1'b0;
    endtask

    initial begin : p_stim
        int n0, n1, wl;
        bit found, seen;
        Reset_L = 1'b0; AS_L = 1'b1; UDS_L = 1'b1; LDS_L = 1'b1;
        RW = 1'b1; SRamSelect_H = 1'b0; Address = '0;
`ifdef SRAM_WRITE_PROTECT_EN
        WriteProtect_H = 1'b0;
`endif
        tick(3);
        Reset_L = 1'b1;
        tick(2);
        chk("reset_state_dut0", 32'(obs[0]), 32'(IDLE_V));
        chk("reset_state_dut1", 32'(obs[1]), 32'(IDLE_V));

        // Word read from block 1
        idle_bus(6);
        req(17'h08000, 1'b1, 1'b0, 1'b0);
        edge3;
        chk("rd_ce", 32'(ce[0]), 32'h0000000D);
        chk("rd_oe", 32'(oe[0]), 32'h0);
        n0 = -1; n1 = -1;
        for (int n = 1; n <= 8; n++) begin
            edge3;
            if (dt[0] == 1'b0 && n0 < 0) n0 = n;
            if (dt[1] == 1'b0 && n1 < 0) n1 = n;
        end
        chk("rd_dtack_edge_ws2", 32'(n0), 32'd4);
        chk("rd_dtack_edge_ws0", 32'(n1), 32'd2);
        AS_L = 1'b1;
        edge3;
        chk("rd_release_dtack", 32'(dt[0]), 32'h1);
        chk("rd_release_ce", 32'(ce[0]), 32'hF);

        // Lower-byte write to the top of block 3
        idle_bus(6);
        req(17'h1FFFE, 1'b0, 1'b1, 1'b0);
        edge3;
        chk("wr_ce", 32'(ce[0]), 32'h00000007);
        chk("wr_lanes", 32'({ub[0], lb[0]}), 32'h2);
        chk("wr_we_setup", 32'(we[0]), 32'h1);
        wl = 0; found = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            edge3;
            if (!found && dt[0] == 1'b0) begin
                found = 1'b1;
                chk("wr_we_at_dtack", 32'(we[0]), 32'h1);
            end
            if (!found && we[0] == 1'b0) wl++;
        end
        chk("wr_dtack_seen", 32'(found), 32'h1);
        chk("wr_we_cycles", 32'(wl), 32'd3);

        // Back-to-back reads, AS_L high for a single edge
        AS_L = 1'b1;
        tick(6);
        req(17'h04000, 1'b1, 1'b0, 1'b0);
        tick(8);
        AS_L = 1'b1;
        edge3;
        AS_L = 1'b0;
        n0 = -1; n1 = -1;
        for (int n = 1; n <= 8; n++) begin
            edge3;
            if (ce[0] != 4'hF && n0 < 0) n0 = n;
            if (ce[1] != 4'hF && n1 < 0) n1 = n;
        end
        chk("b2b_setup_rc1", 32'(n0), 32'd2);
        chk("b2b_setup_rc3", 32'(n1), 32'd4);

        // Write aborted during ACCESS
        idle_bus(8);
        req(17'h10000, 1'b0, 1'b0, 1'b0);
        edge3;
        edge3;
        chk("abort_we_low", 32'(we[0]), 32'h0);
        AS_L = 1'b1;
        edge3;
        chk("abort_we_release", 32'(we[0]), 32'h1);
        seen = 1'b0;
        for (int n = 0; n < 6; n++) begin
            edge3;
            if (dt[0] == 1'b0 || dt[1] == 1'b0) seen = 1'b1;
        end
        chk("abort_no_dtack", 32'(seen), 32'h0);
        chk("abort_idle", 32'(busy[0]), 32'h0);

        // Asynchronous reset in the middle of ACCESS
        idle_bus(6);
        req(17'h0C000, 1'b0, 1'b0, 1'b0);
        edge3;
        edge3;
        Reset_L = 1'b0;
        #1;
        chk("midreset_dut0", 32'(obs[0]), 32'(IDLE_V));
        chk("midreset_dut1", 32'(obs[1]), 32'(IDLE_V));
        idle_bus(2);
        Reset_L = 1'b1;
        tick(2);

`ifdef SRAM_WRITE_PROTECT_EN
        idle_bus(6);
        WriteProtect_H = 1'b1;
        req(17'h00010, 1'b0, 1'b0, 1'b0);
        edge3;
        chk("wp_berr", 32'(berr[0]), 32'h0);
        chk("wp_no_ce", 32'(ce[0]), 32'hF);
        chk("wp_no_we", 32'(we[0]), 32'h1);
        chk("wp_no_dtack", 32'(dt[0]), 32'h1);
        WriteProtect_H = 1'b0;
`endif

        // Random bus cycles; inputs are scrambled after the first edge
        for (int t = 0; t < 200; t++) begin
            int hold, gap;
            hold = int'($urandom_range(1, 10));
            gap  = int'($urandom_range(0, 3));
            Address      = 17'($urandom);
            RW           = 1'($urandom);
            UDS_L        = 1'($urandom);
            LDS_L        = 1'($urandom);
            SRamSelect_H = ($urandom_range(0, 7) != 0);
`ifdef SRAM_WRITE_PROTECT_EN
            WriteProtect_H = 1'($urandom);
`endif
            AS_L = 1'b0;
            tick(1);
            Address      = 17'($urandom);
            RW           = 1'($urandom);
            SRamSelect_H = 1'($urandom);
            tick(hold);
            idle_bus(gap);
        end

        idle_bus(8);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
